obstacle_scheduler: RTL

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/obstacle_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_scheduler
//  Description : Paces obstacle spawns for the game. A random interval
//                {rnd,4'b1111} (15..255 frame ticks) is loaded, counted
//                down on frame ticks, then a spawn request is held until
//                the obstacle engine acknowledges it or the ack timeout
//                expires (in which case a single 'missed' pulse is issued).
//
//  Ports
//    clk        in   1  system clock, rising edge active
//    reset      in   1  synchronous, active-high reset
//    en         in   1  game running; 0 parks the scheduler in IDLE
//    tick       in   1  one-cycle frame pulse (unit of the spawn gap)
//    rnd        in   4  random bits from the LFSR generator
//    spawn_ack  in   1  obstacle engine accepted the request
//    rnd_step   out  1  one-cycle pulse advancing the random generator
//    spawn_req  out  1  level, high for every cycle spent in REQ
//    missed     out  1  one-cycle pulse, request abandoned on timeout
//    gap        out  8  currently loaded interval, in ticks
//    count      out  8  ticks remaining before the request
//    state      out  2  IDLE=0, LOAD=1, COUNT=2, REQ=3
//
//  Revision    : 1.0  initial release
// ============================================================================
module obstacle_scheduler #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       tick,
    input  logic [3:0] rnd,
    input  logic       spawn_ack,
    output logic       rnd_step,
    output logic       spawn_req,
    output logic       missed,
    output logic [7:0] gap,
    output logic [7:0] count,
    output logic [1:0] state
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_REQ   = 2'd3;

    // The timeout counter starts at 0 on the first REQ cycle, so the last
    // permitted REQ cycle is the one where it holds ACK_TIMEOUT-1.
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [7:0] r_gap;
    logic [7:0] r_count;
    logic [7:0] r_to_cnt;
    logic       r_missed;

    logic       w_in_req;
    logic       w_timeout_hit;
    logic       w_req_exit;
    logic       w_last_tick;
    logic [7:0] w_load_val;

    // Low nibble forced to all-ones gives the 15-tick minimum interval.
    assign w_load_val    = {rnd, 4'b1111};

    assign w_in_req      = (r_state == S_REQ);

    // An ack in the same cycle as the timeout wins, so the timeout only
    // counts when no ack is present.
    assign w_timeout_hit = w_in_req && !spawn_ack && (r_to_cnt == C_TIMEOUT_LAST);

    // Either way the request is over; the en level picks LOAD or IDLE.
    assign w_req_exit    = w_in_req && (spawn_ack || w_timeout_hit);

    // Treat count<=1 as the final tick so a zero count can never wrap.
    assign w_last_tick   = (r_state == S_COUNT) && tick && (r_count <= 8'd1);

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_state = en ? S_COUNT : S_IDLE;
            end
            S_COUNT: begin
                if (!en) begin
                    w_next_state = S_IDLE;
                end else if (w_last_tick) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (w_req_exit) begin
                    w_next_state = en ? S_LOAD : S_IDLE;
                end else if (!en) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: interval, countdown, ack timeout, missed pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap    <= 8'd0;
            r_count  <= 8'd0;
            r_to_cnt <= 8'd0;
            r_missed <= 1'b0;
        end else begin
            r_missed <= w_timeout_hit;
            case (r_state)
                S_IDLE: begin
                    r_count  <= 8'd0;
                    r_to_cnt <= 8'd0;
                end
                S_LOAD: begin
                    // rnd is sampled while rnd_step is high; the generator
                    // advances on this same edge, ready for the next load.
                    if (en) begin
                        r_gap   <= w_load_val;
                        r_count <= w_load_val;
                    end else begin
                        r_count <= 8'd0;
                    end
                    r_to_cnt <= 8'd0;
                end
                S_COUNT: begin
                    if (!en) begin
                        r_count <= 8'd0;
                    end else if (tick) begin
                        if (r_count <= 8'd1) begin
                            r_count <= 8'd0;
                        end else begin
                            r_count <= r_count - 8'd1;
                        end
                    end
                    // Holding zero here means REQ always starts from zero.
                    r_to_cnt <= 8'd0;
                end
                S_REQ: begin
                    r_count <= 8'd0;
                    if (w_req_exit || !en) begin
                        r_to_cnt <= 8'd0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                default: begin
                    r_count  <= 8'd0;
                    r_to_cnt <= 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        rnd_step  = (r_state == S_LOAD);
        spawn_req = (r_state == S_REQ);
        missed    = r_missed;
        gap       = r_gap;
        count     = r_count;
        state     = r_state;
    end

endmodule
`default_nettype wire
